// File: rtl/axi_write_slave_bridge.sv
// axi_write_slave_bridge: AXI4 write responder streaming W beats to a local write port
// Ports: s_axi_aw* accepts one burst at a time, s_axi_w* is forwarded beat by beat
// to write_valid/addr/data/strb (handshake with write_ready), s_axi_b* returns one response.
// Optional macro AXI_WR_PROTOCOL_CHECK_EN: sticky per-burst SLVERR on wlast misuse or oversize awsize.
module axi_write_slave_bridge #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              write_valid,
  output logic [AW-1:0]     write_addr,
  output logic [DW-1:0]     write_data,
  output logic [DW/8-1:0]   write_strb,
  input  logic              write_ready
);
  localparam logic [2:0] LB = 3'($clog2(DW/8));
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state;
  logic [AW-1:0] addr, step, mask, next_addr;
  logic [7:0] len, cnt;
  logic [2:0] sz;
  logic [1:0] burst;
  logic err, beat, last, wrap, beat_err, size_err;
  assign s_axi_wready = state == DATA && write_ready;
  assign write_valid = state == DATA && s_axi_wvalid;
  assign write_addr = addr;
  assign write_data = s_axi_wdata;
  assign write_strb = s_axi_wstrb;
  assign beat = write_valid && write_ready;
  assign last = cnt == len;
  assign step = AW'(1) << sz;
  // only power-of-two lengths 2..16 wrap; anything else steps like INCR
  assign wrap = burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  assign mask = ((AW'(len) + AW'(1)) << sz) - AW'(1);
  assign next_addr = burst == 2'b00 ? addr
                   : wrap ? (addr & ~mask) | ((addr + step) & mask)
                   : addr + step;
`ifdef AXI_WR_PROTOCOL_CHECK_EN
  assign beat_err = s_axi_wlast != last;
  assign size_err = s_axi_awsize > LB;
`else
  assign beat_err = s_axi_wlast & 1'b0;
  assign size_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      s_axi_awready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_bid <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      sz <= '0;
      burst <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_bid <= s_axi_awid;
            addr <= s_axi_awaddr;
            len <= s_axi_awlen;
            sz <= s_axi_awsize > LB ? LB : s_axi_awsize;
            burst <= s_axi_awburst;
            cnt <= '0;
            err <= size_err;
            s_axi_awready <= 1'b0;
            state <= DATA;
          end else s_axi_awready <= 1'b1;
        end
        DATA: begin
          if (beat) begin
            cnt <= cnt + 8'd1;
            addr <= next_addr;
            err <= err | beat_err;
            if (last) begin
              state <= RESP;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp <= (err | beat_err) ? 2'b10 : 2'b00;
            end
          end
        end
        RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_awready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi_write_slave_bridge.md
Name: axi_write_slave_bridge

Overview:
- AXI4 write-channel responder; the write-direction counterpart of the existing read-channel master/slave bridges.
- Accepts one AW burst at a time, streams W beats to a local write port with per-beat addresses, then returns a single B response.
- Sits between an AXI write master (s_axi_*) and the local memory/mesh write interface (write_*).

Parameters:
IDW, 12, AXI ID width
AW, 32, address width
DW, 64, data width in bits (power of two, 8..64)

Ports:
clk  in  1  global clock
resetn  in  1  asynchronous active-low reset
s_axi_awid  in  IDW  write address ID
s_axi_awaddr  in  AW  burst start address
s_axi_awlen  in  8  beats minus one
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DW  write data
s_axi_wstrb  in  DW/8  byte strobes
s_axi_wlast  in  1  last beat marker
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  IDW  response ID (latched awid)
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
write_valid  out  1  local write beat valid
write_addr  out  AW  byte address of current beat
write_data  out  DW  = s_axi_wdata
write_strb  out  DW/8  = s_axi_wstrb
write_ready  in  1  local side accepts beat

Behaviour:
- Reset (async, resetn=0): state IDLE; awready=0, wready=0, bvalid=0, bresp=00, bid=0, write_valid=0, counters/address registers 0. First rising clk after deassertion registers awready=1.
- Reset mid-burst: burst abandoned; no B response issued; all outputs return to reset values immediately.
- FSM IDLE / DATA / RESP:
  - IDLE: awready=1 (registered). On awvalid&awready, latch awid/addr/len/size/burst, clear beat counter and error flag, awready<=0, go DATA.
  - DATA: wready = write_ready; write_valid = wvalid; data/strb pass through combinationally (zero-latency). Beat fires on wvalid&wready, which coincides with write_valid&write_ready. Each beat increments counter and advances address. Beat with counter==len: go RESP, bvalid<=1 next cycle.
  - RESP: bvalid held with stable bid/bresp until bready. On bvalid&bready: bvalid<=0, awready<=1, go IDLE.
- Max throughput: one W beat per cycle. AW-to-first-beat: 1 cycle. Last-beat-to-bvalid: 1 cycle. bvalid-accept-to-next-awready: 1 cycle.
- AW presented during DATA/RESP is ignored (awready=0); W presented in IDLE/RESP is not accepted (wready=0).
- Burst length is awlen+1 (1..256); awlen alone terminates the burst, never wlast.
- Address generation, step = 1<<awsize:
  - FIXED: address unchanged.
  - INCR and reserved 11: addr + step, modulo 2^AW.
  - WRAP: window = (awlen+1)*step, aligned down. On reaching window top, wrap to window base. Legal awlen for WRAP is 1, 3, 7 or 15; any other awlen is treated as INCR.
- awsize > log2(DW/8): clamped to log2(DW/8) for stepping.
- bresp is 00 unless the optional error feature flags an error.

Optional Feature:
- Macro: AXI_WR_PROTOCOL_CHECK_EN
- Defined: sticky per-burst error flag set by any of: wlast=1 on a non-final beat; wlast=0 on the final beat; awsize > log2(DW/8). Flag set gives bresp=10 (SLVERR). Beats are still forwarded unchanged.
- Undefined: no checking; bresp constant 00; wlast ignored.

Test Plan:
- AW INCR addr 0x1000, len 3, size 3; W 4 beats back-to-back, write_ready=1 -> write_addr 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; bvalid one cycle after beat 4, bresp 00, bid = awid.
- AW WRAP addr 0x1038, len 3, size 3 -> write_addr 0x1038, 0x1020, 0x1028, 0x1030.
- AW FIXED addr 0x40, len 2; write_ready toggled 1,0,1,0,1 -> wready mirrors write_ready; 3 beats all at 0x40; no beat lost or duplicated.
- B backpressure: bready=0 for 5 cycles -> bvalid/bid/bresp stable and awready=0 throughout; bready=1 -> awready=1 next cycle.
- With AXI_WR_PROTOCOL_CHECK_EN, len 3, wlast on beat 2 -> still 4 beats forwarded, bresp=10. Without the macro, same stimulus -> bresp=00.
- resetn pulsed low after beat 2 of a len-7 burst -> all outputs reset asynchronously, no bvalid. A new AW then completes normally.
